// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sharing of a single 8-bit adder among NREQ requesters.
// Define ADD_ARB_STATS_EN to add per-requester completion counters (grant_cnt, stats_clr).
module add_arbiter #(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int ADD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*8-1:0]   req_a,
  input  logic [NREQ*8-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                res_valid,
  output logic [7:0]          res_data,
  output logic [IDW-1:0]      res_id,
  input  logic                res_ready,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  input  logic [7:0]          add_x,
`ifdef ADD_ARB_STATS_EN
  output logic [NREQ*16-1:0]  grant_cnt,
  input  logic                stats_clr,
`endif
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ-1);

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [2:0]      wait_cnt;
  logic [NREQ-1:0] rot_valid;
  logic [IDW-1:0]  win_off;
  logic [IDW:0]    win_sum;
  logic [IDW-1:0]  win_id;
  logic            any_valid;
  logic            grant;
  logic            handshake;

  // Rotate the valid vector so bit 0 is the requester at rr_ptr; the lowest set
  // bit of the rotated view is then the round-robin winner.
  assign rot_valid = NREQ'({req_valid, req_valid} >> rr_ptr);

  always_comb begin
    win_off = '0;
    for (int j = NREQ-1; j >= 0; j--) begin
      if (rot_valid[j]) win_off = j[IDW-1:0];
    end
  end

  assign win_sum   = {1'b0, rr_ptr} + {1'b0, win_off};
  assign win_id    = (win_sum >= NREQ_W) ? IDW'(win_sum - NREQ_W) : win_sum[IDW-1:0];
  assign any_valid = |req_valid;
  assign grant     = (state == IDLE) && any_valid;
  assign handshake = (state == RESP) && res_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_valid) state_nxt = WAIT;
      WAIT:    if (wait_cnt == '0) state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is gated by reset so nothing can be accepted while the block is held.
  always_comb begin
    req_ready = '0;
    if (grant && reset) req_ready[win_id] = 1'b1;
    res_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // Operands only change on a grant, so the adder inputs stay quiet otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_a    <= '0;
      add_b    <= '0;
      res_id   <= '0;
      res_data <= '0;
      wait_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      if (grant) begin
        add_a    <= req_a[{win_id, 3'b000} +: 8];
        add_b    <= req_b[{win_id, 3'b000} +: 8];
        res_id   <= win_id;
        wait_cnt <= 3'(ADD_LATENCY);
      end else if (state == WAIT) begin
        if (wait_cnt == '0) res_data <= add_x;
        else                wait_cnt <= wait_cnt - 3'd1;
      end
      if (handshake) rr_ptr <= (res_id == LAST_ID) ? '0 : res_id + IDW'(1);
    end
  end

`ifdef ADD_ARB_STATS_EN
  // Clear takes priority over a coinciding handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt <= '0;
    end else if (stats_clr) begin
      grant_cnt <= '0;
    end else if (handshake && (grant_cnt[{res_id, 4'b0000} +: 16] != 16'hFFFF)) begin
      grant_cnt[{res_id, 4'b0000} +: 16] <= grant_cnt[{res_id, 4'b0000} +: 16] + 16'd1;
    end
  end
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: scoreboard bench for add_arbiter with a round-robin reference model.
// Stats checks are compiled in when ADD_ARB_STATS_EN is defined.
module tb_add_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int LAT  = 1;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ*8-1:0] req_a = '0;
   logic [NREQ*8-1:0] req_b = '0;
   logic [NREQ-1:0]   req_ready;
   logic              res_valid;
   logic [7:0]        res_data;
   logic [IDW-1:0]    res_id;
   logic              res_ready = 1'b1;
   logic [7:0]        add_a;
   logic [7:0]        add_b;
   logic [7:0]        add_x;
   logic              busy;
`ifdef ADD_ARB_STATS_EN
   logic [NREQ*16-1:0] grant_cnt;
   logic               stats_clr = 1'b0;
`endif

   typedef struct {
      int         id;
      logic [7:0] sum;
      int         gcyc;
   } exp_t;

   exp_t            exp_q[$];
   int              grant_log[$];
   int              total = 0;
   int              bad = 0;
   int              cyc = 0;
   int              m_ptr = 0;
   bit              m_busy = 0;
   bit              seen_valid = 0;
   logic [NREQ-1:0] accepted = '0;
   int              win;
   logic [NREQ-1:0] exp_ready;
   exp_t            e;

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   add_arbiter #(.NREQ(NREQ), .IDW(IDW), .ADD_LATENCY(LAT)) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_a(req_a),
      .req_b(req_b),
      .req_ready(req_ready),
      .res_valid(res_valid),
      .res_data(res_data),
      .res_id(res_id),
      .res_ready(res_ready),
      .add_a(add_a),
      .add_b(add_b),
      .add_x(add_x),
`ifdef ADD_ARB_STATS_EN
      .grant_cnt(grant_cnt),
      .stats_clr(stats_clr),
`endif
      .busy(busy)
   );

   // Behavioural adder standing in for the shared adder instance.
   generate
      if (LAT == 0) begin : gComb
         assign add_x = add_a + add_b;
      end else begin : gPipe
         logic [7:0] pipe [LAT];
         always @(posedge clk) begin
            pipe[0] <= add_a + add_b;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
         end
         assign add_x = pipe[LAT-1];
      end
   endgenerate

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference arbitration: first valid requester scanning up from the pointer.
   function automatic int modelWinner(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   // Monitor: predicts each grant from the model, queues the expected result and
   // compares every presented response against the head of the queue.
   always @(negedge clk) begin
      accepted = req_valid & req_ready;
      if (!reset) begin
         exp_q.delete();
         m_ptr      = 0;
         m_busy     = 0;
         seen_valid = 0;
         checkOutput("ready_in_reset", 32'(req_ready), 32'(0));
      end else begin
         checkOutput("busy", 32'(busy), 32'(m_busy));
         if (!m_busy) begin
            win       = modelWinner(req_valid, m_ptr);
            exp_ready = (win < 0) ? '0 : NREQ'(1) << win;
            checkOutput("grant", 32'(req_ready), 32'(exp_ready));
            if (win >= 0) begin
               e.id   = win;
               e.sum  = req_a[win*8 +: 8] + req_b[win*8 +: 8];
               e.gcyc = cyc;
               exp_q.push_back(e);
               grant_log.push_back(win);
               m_busy     = 1;
               seen_valid = 0;
            end
         end else begin
            checkOutput("ready_while_busy", 32'(req_ready), 32'(0));
         end
         if (res_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL res_valid: got 1 with no operation outstanding, expected 0");
            end else begin
               if (!seen_valid) begin
                  checkOutput("latency", 32'(cyc - exp_q[0].gcyc), 32'(2 + LAT));
                  seen_valid = 1;
               end
               checkOutput("res_id", 32'(res_id), 32'(exp_q[0].id));
               checkOutput("res_data", 32'(res_data), 32'(exp_q[0].sum));
               if (res_ready) begin
                  m_ptr  = (exp_q[0].id + 1) % NREQ;
                  m_busy = 0;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // One requester raises a request with the given operands.
   task automatic applyStimulus(input int idx, input logic [7:0] a, input logic [7:0] b);
      req_a[idx*8 +: 8] = a;
      req_b[idx*8 +: 8] = b;
      req_valid[idx]    = 1'b1;
   endtask

   // Advance one cycle; requesters that were granted drop their valid.
   task automatic stepCycle();
      @(posedge clk);
      #1;
      req_valid = req_valid & ~accepted;
   endtask

   task automatic waitIdle(input int bound);
      int n = 0;
      while ((busy || exp_q.size() != 0 || req_valid != '0) && n < bound) begin
         stepCycle();
         n++;
      end
      if (busy || exp_q.size() != 0 || req_valid != '0) begin
         total++;
         bad++;
         $display("[TB] FAIL wait_idle: still active after %0d cycles, expected idle", bound);
      end
   endtask

   task automatic waitResValid(input int bound);
      int n = 0;
      while (!res_valid && n < bound) begin
         stepCycle();
         n++;
      end
      if (!res_valid) begin
         total++;
         bad++;
         $display("[TB] FAIL wait_res_valid: no response after %0d cycles, expected res_valid", bound);
      end
   endtask

   initial begin
      // Reset values
      #2;
      checkOutput("rst_res_valid", 32'(res_valid), 32'(0));
      checkOutput("rst_busy", 32'(busy), 32'(0));
      checkOutput("rst_add_a", 32'(add_a), 32'(0));
      checkOutput("rst_add_b", 32'(add_b), 32'(0));
      checkOutput("rst_res_data", 32'(res_data), 32'(0));
      checkOutput("rst_res_id", 32'(res_id), 32'(0));
      stepCycle();
      stepCycle();
      reset = 1'b1;
      stepCycle();

      // Single request and its exact latency
      applyStimulus(0, 8'h12, 8'h34);
      #1;
      checkOutput("t1_ready", 32'(req_ready), 32'(4'b0001));
      stepCycle();
      stepCycle();
      checkOutput("t1_early_valid", 32'(res_valid), 32'(0));
      stepCycle();
      checkOutput("t1_valid", 32'(res_valid), 32'(1));
      checkOutput("t1_data", 32'(res_data), 32'(8'h46));
      checkOutput("t1_id", 32'(res_id), 32'(0));
      waitIdle(20);

      // Modulo-256 wrap on requester 3, which also returns the pointer to 0
      applyStimulus(3, 8'hF0, 8'h20);
      waitResValid(20);
      checkOutput("t2_data", 32'(res_data), 32'(8'h10));
      checkOutput("t2_id", 32'(res_id), 32'(3));
      waitIdle(20);

      // All requesters continuously valid
      grant_log.delete();
      for (int i = 0; i < NREQ; i++) applyStimulus(i, 8'($urandom), 8'($urandom));
      for (int n = 0; n < 100 && grant_log.size() < 5; n++) begin
         stepCycle();
         for (int i = 0; i < NREQ; i++)
            if (!req_valid[i]) applyStimulus(i, 8'($urandom), 8'($urandom));
      end
      req_valid = '0;
      checkOutput("t3_grants", 32'(grant_log.size() >= 5), 32'(1));
      if (grant_log.size() >= 5) begin
         checkOutput("t3_order0", 32'(grant_log[0]), 32'(0));
         checkOutput("t3_order1", 32'(grant_log[1]), 32'(1));
         checkOutput("t3_order2", 32'(grant_log[2]), 32'(2));
         checkOutput("t3_order3", 32'(grant_log[3]), 32'(3));
         checkOutput("t3_order4", 32'(grant_log[4]), 32'(0));
      end
      waitIdle(20);

      // Backpressure with a second requester waiting
      res_ready = 1'b0;
      applyStimulus(1, 8'h55, 8'h66);
      applyStimulus(2, 8'h01, 8'h02);
      waitResValid(20);
      for (int n = 0; n < 10; n++) begin
         stepCycle();
         checkOutput("t4_valid", 32'(res_valid), 32'(1));
         checkOutput("t4_data", 32'(res_data), 32'(8'hBB));
         checkOutput("t4_id", 32'(res_id), 32'(1));
         checkOutput("t4_ready", 32'(req_ready), 32'(0));
      end
      res_ready = 1'b1;
      waitIdle(20);

      // Reset during WAIT; the pointer (3 here) must fall back to 0
      applyStimulus(0, 8'hA5, 8'h11);
      stepCycle();
      applyStimulus(2, 8'h07, 8'h08);
      applyStimulus(3, 8'h09, 8'h0A);
      reset = 1'b0;
      #1;
      checkOutput("t5_res_valid", 32'(res_valid), 32'(0));
      checkOutput("t5_busy", 32'(busy), 32'(0));
      checkOutput("t5_add_a", 32'(add_a), 32'(0));
      checkOutput("t5_ready", 32'(req_ready), 32'(0));
      stepCycle();
      reset = 1'b1;
      #1;
      checkOutput("t5_grant", 32'(req_ready), 32'(4'b0100));
      waitIdle(40);

`ifdef ADD_ARB_STATS_EN
      stats_clr = 1'b1;
      stepCycle();
      stats_clr = 1'b0;
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1, 8'(n), 8'h10);
         waitIdle(20);
      end
      checkOutput("t6_cnt1", 32'(grant_cnt[31:16]), 32'(3));
      checkOutput("t6_cnt0", 32'(grant_cnt[15:0]), 32'(0));
      stats_clr = 1'b1;
      stepCycle();
      stats_clr = 1'b0;
      #1;
      checkOutput("t6_clr", 32'(grant_cnt[31:16]), 32'(0));
`endif

      // Random traffic with random backpressure and occasional withdrawals
      for (int c = 0; c < 1500; c++) begin
         stepCycle();
         res_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i]) begin
               if ($urandom_range(0, 3) == 0) applyStimulus(i, 8'($urandom), 8'($urandom));
            end else if ($urandom_range(0, 31) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
      end
      req_valid = '0;
      res_ready = 1'b1;
      waitIdle(40);
      checkOutput("queue_drained", 32'(exp_q.size()), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
